// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and clock/baud defaults shared by the UART transmitter and receiver
package uart_pkg;
   localparam int UART_CLK_FREQ  = 50000000;
   localparam int UART_BAUD_RATE = 115200;
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;
   function automatic logic parity_bit(input logic [7:0] d, input logic odd);
      return ^d ^ odd;
   endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter, ticks on the last clock of each bit and restarts on clear
module uart_baud_gen #(
   parameter int BAUD_TICK_COUNT = 434
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);
   logic [15:0] cnt;
   assign tick = cnt == 16'(BAUD_TICK_COUNT - 1);
   always_ff @(posedge clk)
      cnt <= (rst || clear || tick) ? '0 : cnt + 16'd1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter with optional parity and 1 or 2 stop bits, registered tx output
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ        = UART_CLK_FREQ,
   parameter int BAUD_RATE       = UART_BAUD_RATE,
   parameter int BAUD_TICK_COUNT = CLK_FREQ / BAUD_RATE,
   parameter int PARITY_EN       = 0,
   parameter int PARITY_ODD      = 0,
   parameter int STOP_BITS       = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       data_ready,
   output logic       tx,
   output logic       busy,
   output logic       tx_done
);
   logic [2:0] state;
   logic [7:0] sh;
   logic [2:0] idx;
   logic       par;
   logic       tick;
   logic       accept;
   assign data_ready = state == ST_IDLE && !rst;
   assign accept     = data_valid && data_ready;
   assign busy       = state != ST_IDLE;
   uart_baud_gen #(.BAUD_TICK_COUNT(BAUD_TICK_COUNT)) u_baud (
      .clk(clk),
      .rst(rst),
      .clear(accept),
      .tick(tick)
   );
   // tx is loaded with the level of the state being entered, so it changes with the state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         tx      <= 1'b1;
         tx_done <= 1'b0;
         sh      <= '0;
         idx     <= '0;
         par     <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         if (accept) begin
            state <= ST_START;
            tx    <= 1'b0;
            sh    <= data_in;
            par   <= parity_bit(data_in, PARITY_ODD != 0);
            idx   <= '0;
         end else if (tick) begin
            case (state)
               ST_START: begin
                  state <= ST_DATA;
                  tx    <= sh[0];
                  idx   <= '0;
               end
               ST_DATA: begin
                  if (idx == 3'd7) begin
                     state <= PARITY_EN != 0 ? ST_PARITY : ST_STOP;
                     tx    <= PARITY_EN != 0 ? par : 1'b1;
                     idx   <= '0;
                  end else begin
                     idx <= idx + 3'd1;
                     tx  <= sh[idx + 3'd1];
                  end
               end
               ST_PARITY: begin
                  state <= ST_STOP;
                  tx    <= 1'b1;
               end
               ST_STOP: begin
                  if (idx == 3'(STOP_BITS - 1)) begin
                     state   <= ST_IDLE;
                     tx_done <= 1'b1;
                     idx     <= '0;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  tx    <= 1'b1;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: checks five uart_tx configurations against constant frame tables and an arithmetic frame model
module tb_uart_tx;
   localparam int NI = 5;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] din [NI];
   logic       dv [NI];
   logic       rdy [NI];
   logic       tx [NI];
   logic       busy [NI];
   logic       done [NI];
   int         checks = 0;
   int         errors = 0;
   always #5 clk = ~clk;
   // 0: 8N1, 1: even parity, 2: odd parity, 3: two stop bits (all 4 clocks/bit); 4: defaults, 434 clocks/bit
   for (genvar g = 0; g < NI; g++) begin : g_dut
      uart_tx #(
         .CLK_FREQ(g == 4 ? 50000000 : 400),
         .BAUD_RATE(g == 4 ? 115200 : 100),
         .PARITY_EN((g == 1 || g == 2) ? 1 : 0),
         .PARITY_ODD(g == 2 ? 1 : 0),
         .STOP_BITS(g == 3 ? 2 : 1)
      ) dut (
         .clk(clk),
         .rst(rst),
         .data_in(din[g]),
         .data_valid(dv[g]),
         .data_ready(rdy[g]),
         .tx(tx[g]),
         .busy(busy[g]),
         .tx_done(done[g])
      );
   end
   function automatic int nk(input int k); return k == 4 ? 434 : 4; endfunction
   function automatic int pe(input int k); return (k == 1 || k == 2) ? 1 : 0; endfunction
   function automatic int po(input int k); return k == 2 ? 1 : 0; endfunction
   function automatic int sb(input int k); return k == 3 ? 2 : 1; endfunction
   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, a, e);
      end
   endtask
   // frame as line levels, one entry per bit slot, LSB = start bit
   task automatic model(input int k, input logic [7:0] d, output logic [11:0] fr, output int slots);
      slots = 1 + 8 + pe(k) + sb(k);
      fr = '1;
      fr[0] = 1'b0;
      fr[8:1] = d;
      if (pe(k) != 0) fr[9] = 1'(($countones(d) + po(k)) % 2);
   endtask
   task automatic send_frame(input int k, input logic [7:0] d, input logic [11:0] fr, input int slots, input bit noise);
      int n, w, e0;
      n = nk(k);
      w = 0;
      while (!rdy[k] && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk($sformatf("ready_k%0d", k), 32'(rdy[k]), 1);
      din[k] = d;
      dv[k] = 1'b1;
      @(negedge clk);
      dv[k] = 1'b0;
      e0 = errors;
      for (int t = 0; t < slots * n; t++) begin
         if (errors == e0) begin
            chk($sformatf("tx_k%0d_t%0d", k, t), 32'(tx[k]), 32'(fr[t / n]));
            chk($sformatf("busy_k%0d_t%0d", k, t), 32'(busy[k]), 1);
            chk($sformatf("done_k%0d_t%0d", k, t), 32'(done[k]), 0);
         end
         if (noise) begin
            din[k] = 8'($urandom);
            dv[k] = (t < slots * n - 1) ? 1'($urandom) : 1'b0;
         end
         @(negedge clk);
      end
      chk($sformatf("end_done_k%0d", k), 32'(done[k]), 1);
      chk($sformatf("end_busy_k%0d", k), 32'(busy[k]), 0);
      chk($sformatf("end_tx_k%0d", k), 32'(tx[k]), 1);
      chk($sformatf("end_ready_k%0d", k), 32'(rdy[k]), 1);
      @(negedge clk);
      chk($sformatf("post_done_k%0d", k), 32'(done[k]), 0);
      chk($sformatf("post_busy_k%0d", k), 32'(busy[k]), 0);
      chk($sformatf("post_tx_k%0d", k), 32'(tx[k]), 1);
   endtask
   typedef struct {
      int          k;
      logic [7:0]  d;
      logic [11:0] fr;
      int          slots;
   } vec_t;
   logic trace [128];
   function automatic logic [7:0] decode(input int s);
      logic [7:0] v;
      for (int i = 0; i < 8; i++) v[i] = trace[s + 4 * (i + 1) + 2];
      return v;
   endfunction
   initial begin
      vec_t        vecs [5];
      logic [11:0] fr;
      int          slots, s1, s2;
      logic [7:0]  d;
      for (int k = 0; k < NI; k++) begin
         din[k] = '0;
         dv[k] = 1'b0;
      end
      vecs[0] = '{0, 8'h55, 12'h2AA, 10};
      vecs[1] = '{1, 8'hA5, 12'h54A, 11};
      vecs[2] = '{2, 8'hA5, 12'h74A, 11};
      vecs[3] = '{3, 8'h00, 12'h600, 11};
      vecs[4] = '{3, 8'hFF, 12'h7FE, 11};
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("rst_tx_k%0d", k), 32'(tx[k]), 1);
         chk($sformatf("rst_busy_k%0d", k), 32'(busy[k]), 0);
         chk($sformatf("rst_done_k%0d", k), 32'(done[k]), 0);
         chk($sformatf("rst_ready_k%0d", k), 32'(rdy[k]), 0);
      end
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < NI; k++) chk($sformatf("rel_ready_k%0d", k), 32'(rdy[k]), 1);
      for (int i = 0; i < 5; i++) send_frame(vecs[i].k, vecs[i].d, vecs[i].fr, vecs[i].slots, 1'b0);
      for (int i = 0; i < 24; i++) begin
         int k;
         k = $urandom_range(0, 3);
         d = 8'($urandom);
         model(k, d, fr, slots);
         repeat ($urandom_range(0, 3)) begin
            chk($sformatf("gap_tx_k%0d", k), 32'(tx[k]), 1);
            @(negedge clk);
         end
         send_frame(k, d, fr, slots, 1'b0);
      end
      // back-to-back with valid held: 0x00 then 0xFF on the two-stop-bit instance
      din[3] = 8'h00;
      dv[3] = 1'b1;
      for (int t = 0; t < 128; t++) begin
         @(negedge clk);
         trace[t] = tx[3];
         if (t == 2) din[3] = 8'hFF;
         if (t == 50) dv[3] = 1'b0;
      end
      s1 = -1;
      s2 = -1;
      for (int t = 0; t < 128; t++) if (s1 < 0 && trace[t] == 1'b0) s1 = t;
      for (int t = 1; t < 128; t++) if (s1 >= 0 && s2 < 0 && t > s1 && trace[t - 1] && !trace[t]) s2 = t;
      chk("b2b_first_start", 32'(s1), 0);
      chk("b2b_period", 32'(s2 - s1), 45);
      if (s1 >= 0 && s2 >= 0 && s2 + 44 < 128) begin
         chk("b2b_idle_tx", 32'(trace[s1 + 44]), 1);
         chk("b2b_byte0", 32'(decode(s1)), 32'h00);
         chk("b2b_byte1", 32'(decode(s2)), 32'hFF);
         chk("b2b_stop1", 32'(trace[s2 + 38]), 1);
         chk("b2b_stop2", 32'(trace[s2 + 42]), 1);
      end else begin
         chk("b2b_frames_found", 32'(s2), 45);
      end
      // reset in the middle of data bit 3
      @(negedge clk);
      din[0] = 8'h5A;
      dv[0] = 1'b1;
      @(negedge clk);
      dv[0] = 1'b0;
      repeat (17) @(negedge clk);
      chk("pre_rst_bit3", 32'(tx[0]), 1);
      chk("pre_rst_busy", 32'(busy[0]), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_tx", 32'(tx[0]), 1);
      chk("abort_busy", 32'(busy[0]), 0);
      chk("abort_done", 32'(done[0]), 0);
      chk("abort_ready", 32'(rdy[0]), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_rel_ready", 32'(rdy[0]), 1);
      chk("abort_rel_done", 32'(done[0]), 0);
      chk("abort_rel_tx", 32'(tx[0]), 1);
      model(0, 8'h3C, fr, slots);
      send_frame(0, 8'h3C, fr, slots, 1'b0);
      // default parameters with data_in and data_valid churning during the frame
      model(4, 8'hC3, fr, slots);
      send_frame(4, 8'hC3, fr, slots, 1'b1);
      repeat (3) begin
         chk("noise_idle_tx", 32'(tx[4]), 1);
         chk("noise_idle_busy", 32'(busy[4]), 0);
         @(negedge clk);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
      $fatal(1);
   end
endmodule
